wg_mem_checker: RTL
===================

Name: wg_mem_checker

Overview:
- Slave-side WorldGuard checker. It is the responder end of the world-ID tag that the core's WG CSRs (SMWG/SSWG/SHWG/SLWG) attach to each memory request.
- Sits between the core-side request/grant/rvalid bus and a memory or peripheral port.
- Each request's address and WID are checked against a rule table.
  - Permitted requests are forwarded unchanged.
  - Denied requests are absorbed and answered locally with an error response, in order with outstanding traffic.
  - The first violation is captured for software.

Parameters:
AddrWidth, 64, request address width
DataWidth, 64, data width
NWorlds, 128, number of worlds; WidWidth = $clog2(NWorlds) = 7
NrRules, 4, rule table entries
MaxOutstanding, 7, max forwarded requests awaiting response

Ports:
clk_i  in  1  clock
rst_ni  in  1  asynchronous active-low reset
en_i  in  1  checking enable; 0 = permit everything
req_i  in  1  upstream request; held stable until gnt_o
gnt_o  out  1  upstream grant
addr_i  in  AddrWidth  request address
we_i  in  1  1 = write
wdata_i  in  DataWidth  write data
be_i  in  DataWidth/8  byte enables
wid_i  in  WidWidth  requester world ID
rvalid_o  out  1  upstream response valid
rdata_o  out  DataWidth  response data
err_o  out  1  response error
dn_req_o / dn_addr_o / dn_we_o / dn_wdata_o / dn_be_o  out  1/AddrWidth/1/DataWidth/DataWidth/8  downstream request
dn_gnt_i  in  1  downstream grant
dn_rvalid_i / dn_rdata_i / dn_err_i  in  1/DataWidth/1  downstream response
rule_base_i  in  NrRules*AddrWidth  inclusive region bases
rule_top_i  in  NrRules*AddrWidth  exclusive region tops
rule_perm_i  in  NrRules*2*NWorlds  per rule, world w: bit 2w = read, bit 2w+1 = write
err_valid_o  out  1  violation captured
err_ovf_o  out  1  further violation while err_valid_o set
err_addr_o / err_wid_o / err_we_o  out  AddrWidth/WidWidth/1  captured violation
err_clr_i  in  1  clear capture registers
irq_o  out  1  equals err_valid_o

Behaviour:
- Reset: state IDLE, outstanding count 0; all error registers, irq_o, rvalid_o, err_o, gnt_o and dn_req_o are 0. Reset mid-transaction drops all in-flight state; no response is owed.
- Match (combinational):
  - Rule i hits when base_i <= addr_i < top_i (unsigned). A rule with top <= base never hits.
  - The lowest-index hit decides.
  - allowed = !en_i OR (hit AND perm bit [2*wid_i + we_i]). No hit means denied.
- Allowed path:
  - dn_req_o = req_i & allowed & (cnt < MaxOutstanding) & state==IDLE.
  - gnt_o = dn_gnt_i under the same qualifier.
  - Request fields pass through combinationally, so latency is 0.
  - Downstream responses pass straight to rvalid_o/rdata_o/err_o.
- Outstanding counter:
  - +1 on dn_req_o & dn_gnt_i; -1 on dn_rvalid_i; both in the same cycle leaves it unchanged.
  - Saturates at 0 if dn_rvalid_i arrives with cnt==0; this is a protocol violation and carries an assertion.
- Denied path, FSM IDLE/RESP:
  - IDLE with denied req_i and cnt>0: gnt_o=0, dn_req_o=0; wait for drain. This preserves in-order responses.
  - IDLE with denied req_i and cnt==0: gnt_o=1, nothing forwarded, capture the violation, go to RESP.
  - RESP: rvalid_o=1, err_o=1, rdata_o=0, gnt_o=0, then back to IDLE. Denied response latency is exactly 1 cycle after grant.
  - dn_rvalid_i cannot occur in RESP, since cnt==0.
- Error capture:
  - On a denied grant with err_valid_o=0: load addr, wid, we and set err_valid_o.
  - On a denied grant with err_valid_o=1: set err_ovf_o; the captured fields are unchanged.
  - err_clr_i clears err_valid_o and err_ovf_o.
  - err_clr_i together with a denied grant in the same cycle: the new violation is captured (valid=1, ovf=0).
- Rule inputs are quasi-static and sampled every cycle; a change while a request is held is re-evaluated.

Decomposition:
- Shared package wg_pkg:
  - WidWidth
  - wg_perm_e (PERM_R=0, PERM_W=1)
  - wg_rule_t struct {base, top, perm}
  - wg_err_t struct {addr, wid, we}
- Sub-module wg_rule_match:
  - Combinational priority matcher: addr, wid, we, rules -> allowed, hit, hit_idx.
  - Reusable by other WG checkers.

Test Plan:
- Rule0 = [0x8000_0000, 0xC000_0000), wid 3 read-only. Read 0x8000_0010 with wid 3 -> forwarded, gnt_o mirrors dn_gnt_i, downstream rdata returned with err_o=0.
- Same rule, write 0x8000_0010 with wid 3 -> no dn_req_o; gnt_o=1 and rvalid_o=1, err_o=1, rdata_o=0 on the next cycle; err_addr_o=0x8000_0010, err_wid_o=3, err_we_o=1, irq_o=1.
- 3 allowed reads outstanding, then a denied read -> gnt_o held 0 until the third dn_rvalid_i; the error response follows all 3 data responses.
- Two denied requests with no clear -> first address kept, err_ovf_o=1. err_clr_i pulsed in the cycle of a third denial -> err_valid_o=1, err_ovf_o=0, third address captured.
- 7 outstanding allowed requests -> eighth not granted. Simultaneous dn_gnt_i and dn_rvalid_i at cnt=6 -> cnt stays 6.
- en_i=0, unmapped address 0x0 -> forwarded. rst_ni asserted in RESP -> rvalid_o=0 and state IDLE immediately.

Source files
------------

// File: rtl/wg_pkg.sv
`default_nettype none
// ---------------------------------------------------------------------------
// wg_pkg : shared WorldGuard widths, permission encoding and rule/error types
// Rev 1.0
// ---------------------------------------------------------------------------
package wg_pkg;

    localparam int AddrWidth      = 64;
    localparam int DataWidth      = 64;
    localparam int BeWidth        = DataWidth / 8;
    localparam int NWorlds        = 128;
    localparam int WidWidth       = $clog2(NWorlds);
    localparam int PermWidth      = 2 * NWorlds;
    localparam int NrRules        = 4;
    localparam int IdxWidth       = $clog2(NrRules);
    localparam int MaxOutstanding = 7;
    localparam int CntWidth       = $clog2(MaxOutstanding + 1);

    typedef enum logic {
        PERM_R = 1'b0,
        PERM_W = 1'b1
    } wg_perm_e;

    typedef struct packed {
        logic [AddrWidth-1:0] base;
        logic [AddrWidth-1:0] top;
        logic [PermWidth-1:0] perm;
    } wg_rule_t;

    typedef struct packed {
        logic [AddrWidth-1:0] addr;
        logic [WidWidth-1:0]  wid;
        logic                 we;
    } wg_err_t;

    // Bit 2*wid is the read permission, 2*wid+1 the write permission.
    function automatic logic [WidWidth:0] perm_bit(input logic [WidWidth-1:0] wid,
                                                   input wg_perm_e            op);
        return {wid, op};
    endfunction

endpackage
`default_nettype wire

// File: rtl/wg_mem_checker_if.sv
`default_nettype none
// ---------------------------------------------------------------------------
// wg_mem_checker_if : request/grant/rvalid memory bus with world-ID tag
// Rev 1.0
// ---------------------------------------------------------------------------
interface wg_mem_checker_if import wg_pkg::*; ();

    logic                 req;
    logic                 gnt;
    logic [AddrWidth-1:0] addr;
    logic                 we;
    logic [DataWidth-1:0] wdata;
    logic [BeWidth-1:0]   be;
    logic [WidWidth-1:0]  wid;
    logic                 rvalid;
    logic [DataWidth-1:0] rdata;
    logic                 err;

    modport master (
        output req, addr, we, wdata, be, wid,
        input  gnt, rvalid, rdata, err
    );

    modport slave (
        input  req, addr, we, wdata, be, wid,
        output gnt, rvalid, rdata, err
    );

endinterface
`default_nettype wire

// File: rtl/wg_rule_match.sv
`default_nettype none
// ---------------------------------------------------------------------------
// wg_rule_match : combinational lowest-index-wins WorldGuard rule matcher
// Rev 1.0
// ---------------------------------------------------------------------------
module wg_rule_match import wg_pkg::*; (
    input  logic                        en_i,
    input  logic [AddrWidth-1:0]        addr_i,
    input  logic [WidWidth-1:0]         wid_i,
    input  logic                        we_i,
    input  wg_rule_t [NrRules-1:0]      rules_i,
    output logic                        allowed_o,
    output logic                        hit_o,
    output logic [IdxWidth-1:0]         hit_idx_o
);

    logic [NrRules-1:0] rule_hit;
    logic               perm_ok;

    // An empty or inverted region (top <= base) can never satisfy both bounds.
    for (genvar i = 0; i < NrRules; i++) begin : g_hit
        assign rule_hit[i] = (addr_i >= rules_i[i].base) && (addr_i < rules_i[i].top);
    end

    always_comb begin
        hit_o     = 1'b0;
        hit_idx_o = '0;
        perm_ok   = 1'b0;
        for (int i = NrRules - 1; i >= 0; i--) begin
            if (rule_hit[i]) begin
                hit_o     = 1'b1;
                hit_idx_o = IdxWidth'(i);
                perm_ok   = rules_i[i].perm[perm_bit(wid_i, wg_perm_e'(we_i))];
            end
        end
    end

    assign allowed_o = !en_i || (hit_o && perm_ok);

endmodule
`default_nettype wire

// File: rtl/wg_mem_checker.sv
`default_nettype none
// ---------------------------------------------------------------------------
// wg_mem_checker : WorldGuard slave-side checker, forwards or locally errors
// Rev 1.0
// ---------------------------------------------------------------------------
module wg_mem_checker import wg_pkg::*; (
    input  logic                           clk_i,
    input  logic                           rst_ni,
    input  logic                           en_i,
    wg_mem_checker_if.slave                up,
    wg_mem_checker_if.master               dn,
    input  logic [NrRules*AddrWidth-1:0]   rule_base_i,
    input  logic [NrRules*AddrWidth-1:0]   rule_top_i,
    input  logic [NrRules*PermWidth-1:0]   rule_perm_i,
    input  logic                           err_clr_i,
    output logic                           err_valid_o,
    output logic                           err_ovf_o,
    output logic [AddrWidth-1:0]           err_addr_o,
    output logic [WidWidth-1:0]            err_wid_o,
    output logic                           err_we_o,
    output logic                           irq_o
);

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_RESP = 1'b1
    } state_e;

    state_e                state_q;
    logic [CntWidth-1:0]   cnt_q, cnt_d;
    wg_err_t               err_q, err_d;
    logic                  err_valid_q, err_valid_d;
    logic                  err_ovf_q, err_ovf_d;

    wg_rule_t [NrRules-1:0] rules;
    logic                   allowed, hit;
    logic [IdxWidth-1:0]    hit_idx;
    logic                   unused_match;
    logic                   idle, fwd, deny_gnt, inc, dec;

    for (genvar i = 0; i < NrRules; i++) begin : g_rules
        assign rules[i] = '{base: rule_base_i[i*AddrWidth +: AddrWidth],
                            top:  rule_top_i[i*AddrWidth +: AddrWidth],
                            perm: rule_perm_i[i*PermWidth +: PermWidth]};
    end

    wg_rule_match u_match (
        .en_i      (en_i),
        .addr_i    (up.addr),
        .wid_i     (up.wid),
        .we_i      (up.we),
        .rules_i   (rules),
        .allowed_o (allowed),
        .hit_o     (hit),
        .hit_idx_o (hit_idx)
    );

    assign unused_match = ^{hit, hit_idx};

    // A denied request only completes once every forwarded one has drained,
    // so its local error response cannot overtake downstream data.
    assign idle     = (state_q == ST_IDLE);
    assign fwd      = up.req && allowed && (cnt_q < CntWidth'(MaxOutstanding)) && idle;
    assign deny_gnt = up.req && !allowed && (cnt_q == '0) && idle;
    assign inc      = fwd && dn.gnt;
    assign dec      = dn.rvalid && (cnt_q != '0);

    assign dn.req   = fwd;
    assign dn.addr  = up.addr;
    assign dn.we    = up.we;
    assign dn.wdata = up.wdata;
    assign dn.be    = up.be;
    assign dn.wid   = up.wid;

    assign up.gnt    = inc || deny_gnt;
    assign up.rvalid = (state_q == ST_RESP) || dn.rvalid;
    assign up.rdata  = (state_q == ST_RESP) ? '0 : dn.rdata;
    assign up.err    = (state_q == ST_RESP) || dn.err;

    always_comb begin
        cnt_d = cnt_q;
        if (inc && !dec) begin
            cnt_d = cnt_q + 1'b1;
        end else if (!inc && dec) begin
            cnt_d = cnt_q - 1'b1;
        end
    end

    // A clear arriving with a fresh denial still records that denial.
    always_comb begin
        err_d       = err_q;
        err_valid_d = err_valid_q;
        err_ovf_d   = err_ovf_q;
        if (err_clr_i) begin
            err_valid_d = 1'b0;
            err_ovf_d   = 1'b0;
        end
        if (deny_gnt) begin
            if (!err_valid_q || err_clr_i) begin
                err_d       = '{addr: up.addr, wid: up.wid, we: up.we};
                err_valid_d = 1'b1;
                err_ovf_d   = 1'b0;
            end else begin
                err_ovf_d   = 1'b1;
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q     <= ST_IDLE;
            cnt_q       <= '0;
            err_q       <= '0;
            err_valid_q <= 1'b0;
            err_ovf_q   <= 1'b0;
        end else begin
            cnt_q       <= cnt_d;
            err_q       <= err_d;
            err_valid_q <= err_valid_d;
            err_ovf_q   <= err_ovf_d;
            case (state_q)
                ST_IDLE: if (deny_gnt) state_q <= ST_RESP;
                ST_RESP: state_q <= ST_IDLE;
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    a_no_rvalid_when_empty: assert property (@(posedge clk_i) disable iff (!rst_ni)
        dn.rvalid |-> (cnt_q != '0));

    assign err_valid_o = err_valid_q;
    assign err_ovf_o   = err_ovf_q;
    assign err_addr_o  = err_q.addr;
    assign err_wid_o   = err_q.wid;
    assign err_we_o    = err_q.we;
    assign irq_o       = err_valid_q;

endmodule
`default_nettype wire
